slp_fwd_fxp_serial: RTL and testbench
=====================================

# slp_fwd_fxp_serial

Serial fixed-point forward pass for a single-layer perceptron. It streams one (input, weight) pair per handshake, accumulates the bias plus all products at full precision, and applies a step activation. It then produces the output `y` and the training error `error = target - y`, which is the error operand consumed by the weight-update datapath. It sits between the sample/weight memories and the weight-update stage, one instance per perceptron output.

## Interface
- `N`, default 8: number of inputs per sample (≥2).
- `I_CONF`, default `DEF_DCONF_FXP`: input element format (dconf_t, FXP).
- `W_CONF`, default `DEF_DCONF_FXP`: weight and bias format.
- `P_CONF`, default `DEF_DCONF_FXP`: format of `sum`, `y`, `target` and `error`. Must be signed, with `prec-frac ≥ 2`.
- Derived: `I_PREC/W_PREC/P_PREC` = conf.prec. `A_PREC = I_PREC+W_PREC+$clog2(N)+1`. `A_FRAC = I_FRAC+W_FRAC`.
- `clk` in 1: clock, rising edge.
- `reset` in 1: reset, asynchronous and active-high.
- `start` in 1: begin a sample. Accepted only in IDLE.
- `bias` in W_PREC: bias, latched on accepted `start`.
- `target` in P_PREC: expected output, 0 or 1.0, latched on accepted `start`.
- `busy` out 1: high in every state except IDLE.
- `in_valid` in 1: element pair valid.
- `in_ready` out 1: high only in ACC.
- `in_idx` out $clog2(N): index of the expected element. Used as the weight/input memory address.
- `in` in I_PREC: input element.
- `weight` in W_PREC: weight for `in_idx`.
- `out_valid` out 1: result valid.
- `out_ready` in 1: result consumed.
- `sum` out P_PREC: accumulator reduced to P_CONF, saturated.
- `y` out P_PREC: step activation output.
- `error` out P_PREC: `target - y`.
- `ovf`, `udf`, `rounded` out 1 each: flags from the `sum` reduction.

## Operation
- FSM: IDLE → ACC → FIN → OUT → IDLE.
- IDLE:
  - `in_ready=0`, `out_valid=0`.
  - On `start=1`: latch `bias` and `target`; load `acc = sext(bias) << I_FRAC`; `in_idx=0`; go to ACC.
- ACC:
  - Each cycle with `in_valid & in_ready`: `acc += in*weight`. The product is full precision: I_PREC+W_PREC bits, A_FRAC fraction bits, sign-extended per `.sign` of each conf.
  - `in_idx` increments on each accepted beat.
  - The beat with `in_idx==N-1` moves to FIN, and `in_idx` wraps to 0.
  - `in_valid` gaps stall without side effects.
- FIN: one cycle. Register the outputs from `acc`:
  - `y = (acc ≥ 0) ? 1.0 : 0`. Here 1.0 = `1<<P_FRAC`, and `acc==0` gives 1.0.
  - `error = target - y`, exact in P_CONF.
  - `sum = acc >>> (A_FRAC-P_FRAC)`, an arithmetic shift that truncates toward −inf. If `P_FRAC > A_FRAC`, left-shift instead.
  - `rounded` = any discarded fraction bit nonzero.
  - If `sum` exceeds the P_CONF maximum: saturate to the max, `ovf=1`. If below the minimum: saturate to the min, `udf=1`.
- OUT:
  - `out_valid=1`; all result outputs held stable.
  - On `out_ready=1`: go to IDLE.
- `start` outside IDLE is ignored, including in the OUT handshake cycle.
- The accumulator never overflows by construction of A_PREC.
- Reset (any state, including mid-ACC):
  - FSM goes to IDLE and `acc=0`, `in_idx=0`.
  - Outputs: `busy=0`, `in_ready=0`, `out_valid=0`, and `sum`, `y`, `error`, `ovf`, `udf`, `rounded` all 0.
  - Partial sums are discarded.

## Timing
- `start` is accepted at edge T0. `in_ready`, and `busy` (which covers ACC, FIN and OUT), are high after T0.
- With `in_valid` held high, the N beats are accepted at edges T1..TN.
- FIN runs during cycle TN..TN+1. `out_valid` and all results are registered at edge TN+1.
- Minimum sample time is N+2 cycles from `start` to `out_valid`, plus 1 cycle in IDLE before the next `start` can be accepted.
- `out_valid` falls at the edge where `out_valid & out_ready` is sampled.
- Result outputs keep their last values in IDLE until the next FIN. Reset clears them.
- `in_idx` is registered and presents the address for the current beat. Weight and input memories must return data combinationally or be prefetched by the feeder.

## Test plan
Configuration for all scenarios: N=4, all confs signed 16-bit with 8 fraction bits.

1. in = {0x0100,0x0200,0xFF00,0x0080}, w = {0x0080,0x0040,0x0100,0x0200}, bias=0, target=0 → sum=0x0100, y=0x0100, error=0xFF00, flags 0, out_valid 6 cycles after `start`.
2. Same in/w, bias=0xFE00, target=0x0100 → sum=0xFF00, y=0, error=0x0100.
3. in and w all 0x7FFF, bias=0 → sum=0x7FFF, ovf=1, rounded=1, y=0x0100.
4. Products summing to exactly 0 with bias=0 → y=0x0100; sum=0.
5. Random `in_valid` gaps, `out_ready` low for 5 cycles, `start` pulsed during ACC and OUT → results are identical to scenario 1, outputs are stable while stalled, and the extra `start` pulses are ignored.
6. `reset` asserted after 2 accepted beats → all outputs 0 immediately (async). A subsequent full sample reproduces scenario 1 exactly.

Source files
------------

// File: rtl/slp_fwd_fxp_serial.sv
`default_nettype none
// ============================================================================
// Module   : slp_fwd_fxp_serial
// Summary  : Serial fixed-point single-layer perceptron forward pass with
//            step activation and training-error output.
// Revision : 1.0
// ============================================================================

package slp_fxp_pkg;
    typedef struct packed {
        bit          sign;
        int unsigned prec;
        int unsigned frac;
    } dconf_t;

    localparam dconf_t DEF_DCONF_FXP = '{sign: 1'b1, prec: 32'd16, frac: 32'd8};
endpackage

module slp_fwd_fxp_serial
    import slp_fxp_pkg::*;
#(
    parameter int     N      = 8,
    parameter dconf_t I_CONF = DEF_DCONF_FXP,
    parameter dconf_t W_CONF = DEF_DCONF_FXP,
    parameter dconf_t P_CONF = DEF_DCONF_FXP
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [W_CONF.prec-1:0] bias,
    input  logic [P_CONF.prec-1:0] target,
    output logic                   busy,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [$clog2(N)-1:0]   in_idx,
    input  logic [I_CONF.prec-1:0] in,
    input  logic [W_CONF.prec-1:0] weight,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [P_CONF.prec-1:0] sum,
    output logic [P_CONF.prec-1:0] y,
    output logic [P_CONF.prec-1:0] error,
    output logic                   ovf,
    output logic                   udf,
    output logic                   rounded
);

    localparam int I_PREC = int'(I_CONF.prec);
    localparam int I_FRAC = int'(I_CONF.frac);
    localparam int W_PREC = int'(W_CONF.prec);
    localparam int W_FRAC = int'(W_CONF.frac);
    localparam int P_PREC = int'(P_CONF.prec);
    localparam int P_FRAC = int'(P_CONF.frac);
    localparam int IDX_W  = $clog2(N);
    localparam int A_PREC = I_PREC + W_PREC + IDX_W + 1;
    localparam int A_FRAC = I_FRAC + W_FRAC;
    localparam int PROD_W = I_PREC + W_PREC + 2;
    localparam int RSH    = (A_FRAC >= P_FRAC) ? (A_FRAC - P_FRAC) : 0;
    localparam int LSH    = (P_FRAC > A_FRAC) ? (P_FRAC - A_FRAC) : 0;
    localparam int EW0    = A_PREC + LSH;
    localparam int EW     = ((EW0 > P_PREC) ? EW0 : P_PREC) + 1;

    localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(N - 1);
    localparam logic [P_PREC-1:0]        P_ONE    = P_PREC'(1) << P_FRAC;
    localparam logic signed [P_PREC-1:0] P_MAX    = {1'b0, {(P_PREC-1){1'b1}}};
    localparam logic signed [P_PREC-1:0] P_MIN    = {1'b1, {(P_PREC-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_FIN  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic signed [A_PREC-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [P_PREC-1:0]        target_q, target_d;
    logic                     busy_q, busy_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic [P_PREC-1:0]        sum_q, sum_d;
    logic [P_PREC-1:0]        y_q, y_d;
    logic [P_PREC-1:0]        error_q, error_d;
    logic                     ovf_q, ovf_d;
    logic                     udf_q, udf_d;
    logic                     rounded_q, rounded_d;

    // Operands widened by one bit so unsigned formats zero-extend cleanly.
    logic signed [I_PREC:0]   in_ext;
    logic signed [W_PREC:0]   w_ext;
    logic signed [W_PREC:0]   bias_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [A_PREC-1:0] prod_a;
    logic signed [A_PREC-1:0] bias_a;

    assign in_ext   = {I_CONF.sign & in[I_PREC-1], in};
    assign w_ext    = {W_CONF.sign & weight[W_PREC-1], weight};
    assign bias_ext = {W_CONF.sign & bias[W_PREC-1], bias};
    assign prod     = PROD_W'(in_ext) * PROD_W'(w_ext);
    assign prod_a   = A_PREC'(prod);
    assign bias_a   = A_PREC'(bias_ext) <<< I_FRAC;

    logic signed [EW-1:0] acc_e;
    logic signed [EW-1:0] sh;
    logic signed [EW-1:0] pmax_e;
    logic signed [EW-1:0] pmin_e;
    logic                 frac_lost;

    assign acc_e  = EW'(acc_q);
    assign pmax_e = EW'(P_MAX);
    assign pmin_e = EW'(P_MIN);

    generate
        if (LSH > 0) begin : g_lshift
            assign sh        = acc_e <<< LSH;
            assign frac_lost = 1'b0;
        end else if (RSH > 0) begin : g_rshift
            assign sh        = acc_e >>> RSH;
            assign frac_lost = |acc_q[RSH-1:0];
        end else begin : g_noshift
            assign sh        = acc_e;
            assign frac_lost = 1'b0;
        end
    endgenerate

    logic              sat_hi;
    logic              sat_lo;
    logic [P_PREC-1:0] sum_n;
    logic [P_PREC-1:0] y_n;

    assign sat_hi = (sh > pmax_e);
    assign sat_lo = (sh < pmin_e);
    assign sum_n  = sat_hi ? P_MAX : (sat_lo ? P_MIN : sh[P_PREC-1:0]);
    assign y_n    = acc_q[A_PREC-1] ? '0 : P_ONE;

    logic beat;
    assign beat = in_valid & in_ready_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        target_d    = target_q;
        busy_d      = busy_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        y_d         = y_q;
        error_d     = error_q;
        ovf_d       = ovf_q;
        udf_d       = udf_q;
        rounded_d   = rounded_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_ACC;
                    acc_d      = bias_a;
                    idx_d      = '0;
                    target_d   = target;
                    busy_d     = 1'b1;
                    in_ready_d = 1'b1;
                end
            end
            S_ACC: begin
                if (beat) begin
                    acc_d = acc_q + prod_a;
                    if (idx_q == LAST_IDX) begin
                        idx_d      = '0;
                        in_ready_d = 1'b0;
                        state_d    = S_FIN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_FIN: begin
                sum_d       = sum_n;
                y_d         = y_n;
                error_d     = target_q - y_n;
                ovf_d       = sat_hi;
                udf_d       = sat_lo;
                rounded_d   = frac_lost;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            target_q    <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            y_q         <= '0;
            error_q     <= '0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            rounded_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            target_q    <= target_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            y_q         <= y_d;
            error_q     <= error_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
            rounded_q   <= rounded_d;
        end
    end

    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign in_idx    = idx_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign y         = y_q;
    assign error     = error_q;
    assign ovf       = ovf_q;
    assign udf       = udf_q;
    assign rounded   = rounded_q;

endmodule

`default_nettype wire

// File: tb/tb_slp_fwd_fxp_serial.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_slp_fwd_fxp_serial
// Summary  : Self-checking bench for slp_fwd_fxp_serial (N=4, Q8.8 formats).
// Revision : 1.0
// ============================================================================
module tb_slp_fwd_fxp_serial;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] bias;
    logic [15:0] target;
    logic [15:0] din;
    logic [15:0] weight;
    logic        busy;
    logic        in_ready;
    logic        out_valid;
    logic        ovf;
    logic        udf;
    logic        rounded;
    logic [1:0]  in_idx;
    logic [15:0] sum;
    logic [15:0] y;
    logic [15:0] error;

    always #5 clk = ~clk;

    slp_fwd_fxp_serial #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bias     (bias),
        .target   (target),
        .busy     (busy),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_idx   (in_idx),
        .in       (din),
        .weight   (weight),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .y        (y),
        .error    (error),
        .ovf      (ovf),
        .udf      (udf),
        .rounded  (rounded)
    );

    int n_run  = 0;
    int n_fail = 0;

    logic [15:0] vin [N];
    logic [15:0] vw  [N];

    logic [15:0] exp_sum, exp_y, exp_err;
    logic        exp_ovf, exp_udf, exp_rnd;

    logic [15:0] o_sum, o_y, o_err;
    logic        o_ovf, o_udf, o_rnd;
    int          lat;
    bit          tout, unstable, idx_bad, post_bad;

    // Reference: exact integer dot product in Q16.16, floor to Q8.8, clamp.
    function automatic void model(input logic [15:0] b, input logic [15:0] t);
        longint acc;
        longint q;
        acc = longint'($signed(b)) * 256;
        for (int i = 0; i < N; i++)
            acc += longint'($signed(vin[i])) * longint'($signed(vw[i]));
        q = acc / 256;
        if ((acc % 256) != 0 && acc < 0) q = q - 1;
        exp_rnd = ((acc % 256) != 0);
        exp_ovf = (q > 32767);
        exp_udf = (q < -32768);
        if (exp_ovf) q = 32767;
        else if (exp_udf) q = -32768;
        exp_sum = q[15:0];
        exp_y   = (acc >= 0) ? 16'h0100 : 16'h0000;
        exp_err = t - exp_y;
    endfunction

    task automatic load_s1();
        vin[0] = 16'h0100; vin[1] = 16'h0200; vin[2] = 16'hFF00; vin[3] = 16'h0080;
        vw[0]  = 16'h0080; vw[1]  = 16'h0040; vw[2]  = 16'h0100; vw[3]  = 16'h0200;
    endtask

    task automatic drive_sample(input logic [15:0] b, input logic [15:0] t,
                                input bit gaps, input int hold, input bit poke);
        int beats;
        int cyc;
        bit rdy;
        tout = 0; unstable = 0; idx_bad = 0; post_bad = 0; lat = 0;
        start = 1'b1; bias = b; target = t;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1; beats = 0;
        bias = 16'($urandom); target = 16'($urandom);
        while (beats < N && cyc < 200) begin
            in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            din      = in_valid ? vin[beats] : 16'($urandom);
            weight   = in_valid ? vw[beats]  : 16'($urandom);
            if (in_idx != 2'(beats)) idx_bad = 1;
            if (poke) start = ($urandom_range(0, 1) == 1);
            rdy = in_ready;
            @(posedge clk); #1;
            cyc++;
            if (in_valid && rdy) beats++;
        end
        in_valid = 1'b0;
        while (!out_valid && cyc < 200) begin
            if (poke) start = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        if (!out_valid) begin
            tout = 1; start = 1'b0;
            return;
        end
        lat = cyc;
        o_sum = sum; o_y = y; o_err = error; o_ovf = ovf; o_udf = udf; o_rnd = rounded;
        for (int k = 0; k < hold; k++) begin
            if (poke) start = 1'b1;
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || sum !== o_sum || y !== o_y || error !== o_err ||
                {ovf, udf, rounded} !== {o_ovf, o_udf, o_rnd})
                unstable = 1;
        end
        out_ready = 1'b1;
        if (poke) start = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; start = 1'b0;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) post_bad = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_run++;
        if ({busy, in_ready, out_valid, ovf, udf, rounded, in_idx} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 00000000",
                     {busy, in_ready, out_valid, ovf, udf, rounded, in_idx});
        end
        n_run++;
        if ({sum, y, error} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 0", {sum, y, error});
        end
        #3 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        load_s1();
        drive_sample(16'h0000, 16'h0000, 1'b0, 0, 1'b0);
        n_run++;
        if (tout || lat != 6) begin
            n_fail++; $display("FAIL basic_latency: got %0d (timeout %0d) required 6", lat, tout);
        end
        n_run++;
        if ({o_sum, o_y, o_err} !== {16'h0100, 16'h0100, 16'hFF00}) begin
            n_fail++; $display("FAIL basic_result: got %h required 01000100ff00", {o_sum, o_y, o_err});
        end
        n_run++;
        if ({o_ovf, o_udf, o_rnd} !== 3'b000) begin
            n_fail++; $display("FAIL basic_flags: got %b required 000", {o_ovf, o_udf, o_rnd});
        end
        n_run++;
        if (idx_bad || post_bad) begin
            n_fail++; $display("FAIL basic_handshake: got idx_bad=%0d post_bad=%0d required 0 0", idx_bad, post_bad);
        end
    endtask

    task automatic test_negative();
        load_s1();
        drive_sample(16'hFE00, 16'h0100, 1'b0, 0, 1'b0);
        n_run++;
        if (tout || {o_sum, o_y, o_err} !== {16'hFF00, 16'h0000, 16'h0100}) begin
            n_fail++; $display("FAIL negative_result: got %h required ff0000000100", {o_sum, o_y, o_err});
        end
        n_run++;
        if ({o_ovf, o_udf, o_rnd} !== 3'b000) begin
            n_fail++; $display("FAIL negative_flags: got %b required 000", {o_ovf, o_udf, o_rnd});
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < N; i++) begin vin[i] = 16'h7FFF; vw[i] = 16'h7FFF; end
        drive_sample(16'h0000, 16'h0000, 1'b0, 0, 1'b0);
        n_run++;
        if (tout || {o_sum, o_y, o_err} !== {16'h7FFF, 16'h0100, 16'hFF00}) begin
            n_fail++; $display("FAIL ovf_result: got %h required 7fff0100ff00", {o_sum, o_y, o_err});
        end
        n_run++;
        if ({o_ovf, o_udf, o_rnd} !== 3'b101) begin
            n_fail++; $display("FAIL ovf_flags: got %b required 101", {o_ovf, o_udf, o_rnd});
        end
        for (int i = 0; i < N; i++) vw[i] = 16'h8000;
        drive_sample(16'h0000, 16'h0000, 1'b0, 0, 1'b0);
        n_run++;
        if (tout || {o_sum, o_y, o_err} !== {16'h8000, 16'h0000, 16'h0000}) begin
            n_fail++; $display("FAIL udf_result: got %h required 800000000000", {o_sum, o_y, o_err});
        end
        n_run++;
        if ({o_ovf, o_udf, o_rnd} !== 3'b010) begin
            n_fail++; $display("FAIL udf_flags: got %b required 010", {o_ovf, o_udf, o_rnd});
        end
    endtask

    task automatic test_zero();
        vin[0] = 16'h0100; vin[1] = 16'h0100; vin[2] = 16'h0300; vin[3] = 16'h0000;
        vw[0]  = 16'h0100; vw[1]  = 16'hFF00; vw[2]  = 16'h0000; vw[3]  = 16'h1234;
        drive_sample(16'h0000, 16'h0100, 1'b0, 0, 1'b0);
        n_run++;
        if (tout || {o_sum, o_y, o_err} !== {16'h0000, 16'h0100, 16'h0000}) begin
            n_fail++; $display("FAIL zero_result: got %h required 000001000000", {o_sum, o_y, o_err});
        end
        n_run++;
        if ({o_ovf, o_udf, o_rnd} !== 3'b000) begin
            n_fail++; $display("FAIL zero_flags: got %b required 000", {o_ovf, o_udf, o_rnd});
        end
    endtask

    task automatic test_stall();
        load_s1();
        drive_sample(16'h0000, 16'h0000, 1'b1, 5, 1'b1);
        n_run++;
        if (tout || {o_sum, o_y, o_err} !== {16'h0100, 16'h0100, 16'hFF00}) begin
            n_fail++; $display("FAIL stall_result: got %h required 01000100ff00", {o_sum, o_y, o_err});
        end
        n_run++;
        if ({o_ovf, o_udf, o_rnd} !== 3'b000) begin
            n_fail++; $display("FAIL stall_flags: got %b required 000", {o_ovf, o_udf, o_rnd});
        end
        n_run++;
        if (unstable || idx_bad || post_bad) begin
            n_fail++;
            $display("FAIL stall_stability: got unstable=%0d idx_bad=%0d post_bad=%0d required 0 0 0",
                     unstable, idx_bad, post_bad);
        end
    endtask

    task automatic test_back_to_back();
        load_s1();
        drive_sample(16'hFE00, 16'h0100, 1'b0, 0, 1'b0);
        drive_sample(16'h0000, 16'h0000, 1'b0, 0, 1'b0);
        n_run++;
        if (tout || lat != 6 || {o_sum, o_y, o_err} !== {16'h0100, 16'h0100, 16'hFF00}) begin
            n_fail++;
            $display("FAIL b2b_result: got %h lat %0d required 01000100ff00 lat 6", {o_sum, o_y, o_err}, lat);
        end
    endtask

    task automatic test_reset_mid();
        load_s1();
        start = 1'b1; bias = 16'h0000; target = 16'h0000;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1;
        din = vin[0]; weight = vw[0];
        @(posedge clk); #1;
        din = vin[1]; weight = vw[1];
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_run++;
        if ({busy, in_ready, out_valid, ovf, udf, rounded, in_idx} !== 8'h00 || {sum, y, error} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got ctrl %b data %h required all 0",
                     {busy, in_ready, out_valid, ovf, udf, rounded, in_idx}, {sum, y, error});
        end
        @(posedge clk); #3;
        reset = 1'b0;
        @(posedge clk); #1;
        drive_sample(16'h0000, 16'h0000, 1'b0, 0, 1'b0);
        n_run++;
        if (tout || lat != 6 || {o_sum, o_y, o_err, o_ovf, o_udf, o_rnd} !== {16'h0100, 16'h0100, 16'hFF00, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_mid_rerun: got %h flags %b lat %0d required 01000100ff00 000 6",
                     {o_sum, o_y, o_err}, {o_ovf, o_udf, o_rnd}, lat);
        end
    endtask

    task automatic test_random();
        logic [15:0] b;
        logic [15:0] t;
        int          k;
        for (int s = 0; s < 16; s++) begin
            k = $urandom_range(6, 16);
            for (int i = 0; i < N; i++) begin
                vin[i] = 16'($urandom_range(0, (1 << k) - 1)) - 16'(1 << (k - 1));
                vw[i]  = 16'($urandom_range(0, (1 << k) - 1)) - 16'(1 << (k - 1));
            end
            b = 16'($urandom_range(0, 16'hFFFF));
            t = ($urandom_range(0, 1) == 1) ? 16'h0100 : 16'h0000;
            model(b, t);
            drive_sample(b, t, (s % 2) == 1, s % 3, (s % 4) == 3);
            n_run++;
            if (tout || {o_sum, o_y, o_err} !== {exp_sum, exp_y, exp_err}) begin
                n_fail++;
                $display("FAIL random_result[%0d]: got %h required %h", s,
                         {o_sum, o_y, o_err}, {exp_sum, exp_y, exp_err});
            end
            n_run++;
            if ({o_ovf, o_udf, o_rnd} !== {exp_ovf, exp_udf, exp_rnd} || unstable || post_bad) begin
                n_fail++;
                $display("FAIL random_flags[%0d]: got %b (unstable %0d post %0d) required %b", s,
                         {o_ovf, o_udf, o_rnd}, unstable, post_bad, {exp_ovf, exp_udf, exp_rnd});
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        bias = '0; target = '0; din = '0; weight = '0;
        test_reset();
        test_basic();
        test_negative();
        test_saturation();
        test_zero();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
